// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, multicycle state set and the
// datapath select encodings also used by the single-cycle decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_e;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        DM_ALUOUT = 2'b00,
        DM_MDR    = 2'b01,
        DM_PC     = 2'b10
    } dm2reg_e;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_REGB   = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMMSH2 = 2'b11
    } alu_src_b_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        pc_src_e    pc_src;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        alu_op_e    alu_op;
        logic       we_reg;
        reg_dst_e   reg_dst;
        dm2reg_e    dm2reg;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    // Dispatch out of DECODE; anything outside the supported set halts the core.
    function automatic state_e decode_next(input logic [5:0] op);
        state_e nxt;
        case (op)
            OP_RTYPE:     nxt = S_EXEC;
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            OP_JAL:       nxt = S_JAL;
            default:      nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational mapping from controller state (plus mem_ready / zero for the
// Mealy-qualified strobes) to the multicycle datapath control bus.
module mc_ctrl_outdec
    import mips_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = AOP_ADD;
                ctrl.pc_src    = PCS_ALU;
                ctrl.ir_we     = mem_ready;
                ctrl.pc_we     = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target goes into ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = AOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = AOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.we_reg  = 1'b1;
                ctrl.reg_dst = RD_RT;
                ctrl.dm2reg  = DM_MDR;
                ctrl.retire  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.retire  = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = AOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.we_reg  = 1'b1;
                ctrl.reg_dst = RD_RD;
                ctrl.dm2reg  = DM_ALUOUT;
                ctrl.retire  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = AOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.we_reg  = 1'b1;
                ctrl.reg_dst = RD_RT;
                ctrl.dm2reg  = DM_ALUOUT;
                ctrl.retire  = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REGB;
                ctrl.alu_op    = AOP_SUB;
                ctrl.pc_src    = PCS_ALUOUT;
                ctrl.pc_we     = zero;
                ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_src = PCS_JUMP;
                ctrl.pc_we  = 1'b1;
                ctrl.retire = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value.
                ctrl.pc_src  = PCS_JUMP;
                ctrl.pc_we   = 1'b1;
                ctrl.we_reg  = 1'b1;
                ctrl.reg_dst = RD_RA;
                ctrl.dm2reg  = DM_PC;
                ctrl.retire  = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic with the
// memory handshake, and the retired-instruction counter.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             we_reg,
    output logic [1:0]       reg_dst,
    output logic [1:0]       dm2reg,
    output logic             retire,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    ctrl_t            ctrl_raw;
    ctrl_t            ctrl;

    mc_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl_raw)
    );

    // Outputs are gated combinationally so nothing leaks while reset is held.
    always_comb begin
        ctrl = ctrl_raw;
        if (!rst_n) begin
            ctrl = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = decode_next(opcode);
            S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXEC:    state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB,
            S_ALUWB,
            S_ADDIWB,
            S_BRANCH,
            S_JUMP,
            S_JAL:     state_d = S_FETCH;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        instret_d = instret_q + CNT_W'(ctrl.retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign mem_req   = ctrl.mem_req;
    assign mem_we    = ctrl.mem_we;
    assign iord      = ctrl.iord;
    assign ir_we     = ctrl.ir_we;
    assign pc_we     = ctrl.pc_we;
    assign pc_src    = ctrl.pc_src;
    assign alu_src_a = ctrl.alu_src_a;
    assign alu_src_b = ctrl.alu_src_b;
    assign alu_op    = ctrl.alu_op;
    assign we_reg    = ctrl.we_reg;
    assign reg_dst   = ctrl.reg_dst;
    assign dm2reg    = ctrl.dm2reg;
    assign retire    = ctrl.retire;
    assign illegal   = ctrl.illegal;
    assign instret   = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-instruction step recipes with
// randomized memory waits, a modular retire counter and per-opcode CPI table.
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;
    localparam int CNT_M = 1 << CNT_W;

    localparam int P_F = 0, P_D = 1, P_MA = 2, P_MR = 3, P_MWB = 4, P_MW = 5,
                   P_EX = 6, P_AWB = 7, P_IEX = 8, P_IWB = 9, P_BR = 10,
                   P_J = 11, P_JAL = 12, P_ILL = 13;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       we_reg;
        logic [1:0] reg_dst;
        logic [1:0] dm2reg;
        logic       retire;
        logic       illegal;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, iord, ir_we, pc_we, alu_src_a;
    logic             we_reg, retire, illegal;
    logic [1:0]       pc_src, alu_src_b, alu_op, reg_dst, dm2reg;
    logic [CNT_W-1:0] instret;
    vec_t             obs;

    int n_assert = 0;
    int n_fail   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .we_reg(we_reg), .reg_dst(reg_dst), .dm2reg(dm2reg), .retire(retire),
        .illegal(illegal), .instret(instret)
    );

    assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                  alu_op, we_reg, reg_dst, dm2reg, retire, illegal};

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Expected control bus for one step of an instruction, from the step tables.
    function automatic vec_t expv(input int ph, input logic rdy, input logic z);
        vec_t v = '0;
        case (ph)
            P_F:   begin v.mem_req = 1; v.alu_src_b = 2'b01; v.ir_we = rdy; v.pc_we = rdy; end
            P_D:   v.alu_src_b = 2'b11;
            P_MA:  begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
            P_MR:  begin v.mem_req = 1; v.iord = 1; end
            P_MWB: begin v.we_reg = 1; v.dm2reg = 2'b01; v.retire = 1; end
            P_MW:  begin v.mem_req = 1; v.mem_we = 1; v.iord = 1; v.retire = rdy; end
            P_EX:  begin v.alu_src_a = 1; v.alu_op = 2'b10; end
            P_AWB: begin v.we_reg = 1; v.reg_dst = 2'b01; v.retire = 1; end
            P_IEX: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
            P_IWB: begin v.we_reg = 1; v.retire = 1; end
            P_BR:  begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_src = 2'b01;
                         v.pc_we = z; v.retire = 1; end
            P_J:   begin v.pc_src = 2'b10; v.pc_we = 1; v.retire = 1; end
            P_JAL: begin v.pc_src = 2'b10; v.pc_we = 1; v.we_reg = 1; v.reg_dst = 2'b10;
                         v.dm2reg = 2'b10; v.retire = 1; end
            P_ILL: v.illegal = 1;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            6'b000000: return 4;
            6'b100011: return 5;
            6'b101011: return 4;
            6'b001000: return 4;
            default:   return 3;
        endcase
    endfunction

    task automatic step(input string tag, input int ph, input logic rdy, input logic z);
        vec_t e;
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
        e = expv(ph, rdy, z);
        chk({tag, "_ctrl"}, 32'(obs), 32'(e));
        chk({tag, "_instret"}, 32'(instret), 32'(model_cnt));
        @(posedge clk);
        if (e.retire) model_cnt = (model_cnt + 1) % CNT_M;
    endtask

    // fw/mw: memory-low cycles in fetch / data access; negative means random.
    task automatic run_instr(input string tag, input logic [5:0] op, input logic z,
                             input int fw, input int mw);
        int ph[$];
        int cyc = 0;
        int waits = 0;
        int nw;
        opcode = op;
        ph = '{P_F, P_D};
        case (op)
            6'b000000: ph = {ph, P_EX, P_AWB};
            6'b100011: ph = {ph, P_MA, P_MR, P_MWB};
            6'b101011: ph = {ph, P_MA, P_MW};
            6'b001000: ph = {ph, P_IEX, P_IWB};
            6'b000100: ph = {ph, P_BR};
            6'b000010: ph = {ph, P_J};
            default:   ph = {ph, P_JAL};
        endcase
        foreach (ph[i]) begin
            if (ph[i] == P_F || ph[i] == P_MR || ph[i] == P_MW) begin
                nw = (ph[i] == P_F) ? fw : mw;
                if (nw < 0) nw = $urandom_range(0, 2);
                for (int k = 0; k < nw; k++) begin
                    step(tag, ph[i], 1'b0, z);
                    cyc++;
                    waits++;
                end
                step(tag, ph[i], 1'b1, z);
            end else begin
                step(tag, ph[i], 1'($urandom_range(0, 1)), z);
            end
            cyc++;
        end
        chk({tag, "_cycles"}, 32'(cyc), 32'(cpi(op) + waits));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("reset_outputs_zero", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        chk("reset_instret", 32'(instret), 32'd0);
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010, 6'b000011};

        do_reset();
        #1;
        chk("post_reset_fetch", 32'(obs), 32'(expv(P_F, 1'b0, 1'b0)));

        run_instr("rtype", 6'b000000, 1'b0, 0, 0);
        run_instr("lw_wait3", 6'b100011, 1'b0, 0, 3);
        run_instr("sw", 6'b101011, 1'b0, 0, 0);
        run_instr("sw_wait2", 6'b101011, 1'b1, 1, 2);
        run_instr("addi", 6'b001000, 1'b0, 0, 0);
        run_instr("beq_z0", 6'b000100, 1'b0, 0, 0);
        run_instr("beq_z1", 6'b000100, 1'b1, 0, 0);
        run_instr("jal", 6'b000011, 1'b0, 0, 0);
        run_instr("j", 6'b000010, 1'b1, 2, 0);

        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 6)];
            run_instr("rand", op, 1'($urandom_range(0, 1)), -1, -1);
        end

        // Counter wrap with a 4-bit count: 17 retirements leave 1.
        do_reset();
        for (int n = 0; n < 17; n++) run_instr("jwrap", 6'b000010, 1'b0, -1, 0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("instret_wrap", 32'(instret), 32'd1);

        // Reset while fetch is stalled on memory.
        step("fetch_stall", P_F, 1'b0, 1'b0);
        step("fetch_stall", P_F, 1'b0, 1'b0);
        do_reset();
        run_instr("after_abort", 6'b001000, 1'b0, 0, 0);

        // Unsupported opcode: halt until reset, no memory traffic.
        opcode = 6'b111111;
        step("ill_fetch", P_F, 1'b1, 1'b0);
        step("ill_decode", P_D, 1'b0, 1'b0);
        for (int n = 0; n < 20; n++)
            step("ill_hold", P_ILL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        do_reset();
        #1;
        chk("ill_reset_fetch", 32'(obs), 32'(expv(P_F, 1'b0, 1'b0)));
        run_instr("post_ill_rtype", 6'b000000, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multicycle main controller for the MIPS core. It sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and writeback steps for the supported opcode set. It replaces the single-cycle decoder when the core is built in multicycle mode. It handles a variable-latency memory handshake and exposes a retired-instruction counter for the performance block.

## Interface
Parameters:
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; the block is in a single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- opcode  in  6  instr[31:26], taken from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write; meaningful only while mem_req=1.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load. Any conditional load is already resolved with zero.
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  00=reg B, 01=constant 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=funct.
- we_reg  out  1  register file write.
- reg_dst  out  2  00=rt, 01=rd, 10=$ra.
- dm2reg  out  2  00=ALUOut, 01=MDR, 10=PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal  out  1  high while the core is halted on an unsupported opcode.
- instret  out  CNT_W  retired-instruction count.

## Operation
- The state register is one-hot or binary; this is an implementation choice.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JAL, ILLEGAL.
- Any control output not listed for a state is 0.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_we=pc_we=mem_ready. This is Mealy qualification.
  - If mem_ready=1, go to DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 000011 → JAL
  - any other opcode → ILLEGAL
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: we_reg=1, reg_dst=00, dm2reg=01, retire=1. Go to FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready; retire=mem_ready; then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: we_reg=1, reg_dst=01, dm2reg=00, retire=1. Go to FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
- ADDIWB: we_reg=1, reg_dst=00, dm2reg=00, retire=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero, retire=1. Go to FETCH.
- JUMP: pc_src=10, pc_we=1, retire=1. Go to FETCH.
- JAL: pc_src=10, pc_we=1, we_reg=1, reg_dst=10, dm2reg=10, retire=1. Go to FETCH.
  - The PC was already incremented in FETCH, so $ra receives PC+4.
- ILLEGAL: illegal=1 and all other controls are 0. The state is held until reset.
- instret increments by 1 on each cycle with retire=1 and wraps modulo 2^CNT_W.

## Timing
- Reset takes effect on a clk edge with rst_n=0.
  - After that edge: state=FETCH and instret=0.
  - While rst_n=0, every control output, retire and illegal are forced to 0 combinationally.
- Reset mid-operation aborts any memory wait. No partial retire is counted.
- Handshake rules:
  - mem_req holds high with stable iord and mem_we until the cycle in which mem_ready=1; the transfer completes in that cycle.
  - mem_ready while mem_req=0 is ignored.
- Cycles per instruction with zero-wait memory: R-type 4, LW 5, SW 4, ADDI 4, BEQ 3, J 3, JAL 3.
  - Each memory wait cycle adds 1.
- retire and a pc_we/we_reg update occur in the same cycle. instret reflects the retirement on the following cycle.
- At most one retire occurs per cycle and none in consecutive cycles. There is no saturation.

## Structure
- The shared package mips_pkg holds:
  - opcode constants
  - state enum
  - reg_dst, dm2reg, alu_op, pc_src and alu_src_b encodings, shared with the single-cycle decoder
- Optional sub-module: mc_ctrl_outdec, a combinational mapping of state, mem_ready and zero to the output bus. The FSM register and instret counter remain in the top module.

## Test plan
- Reset, then R-type (000000) with mem_ready always 1:
  - states FETCH→DECODE→EXEC→ALUWB→FETCH
  - we_reg=1, reg_dst=01 in cycle 4
  - instret=1
- LW with mem_ready held low 3 cycles in MEMRD:
  - mem_req and iord=1 stable for 4 cycles
  - total 8 cycles
  - MEMWB asserts dm2reg=01
- BEQ twice, once with zero=0 and once with zero=1:
  - pc_we=0 then 1 in BRANCH
  - pc_src=01
  - instret increments both times
- JAL:
  - cycle 3 asserts pc_we=1, pc_src=10, we_reg=1, reg_dst=10, dm2reg=10
- Opcode 111111:
  - DECODE→ILLEGAL, illegal=1
  - no mem_req for 20 cycles
  - rst_n low for one edge returns the block to FETCH
- CNT_W=4, 17 JUMP instructions: instret wraps to 1. rst_n low asserted during a FETCH wait: all outputs go to 0 immediately, and instret=0 after the edge.
